mem_port_arbiter: RTL and testbench

//  Shares one single-ported unified memory between the IF stage (instruction

---
 rtl/mem_arb_pkg.sv | 16 +
 rtl/arb_sat_counter.sv | 34 +++
 rtl/mem_port_arbiter.sv | 160 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the IF/MEM unified-memory arbiter.
// State encodings stay plain 2-bit constants so existing encodings are unchanged.
package mem_arb_pkg;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] BUSY_I = 2'd1;
  localparam logic [1:0] BUSY_D = 2'd2;
  localparam logic [1:0] RESP   = 2'd3;

  localparam logic [31:0] ERR_DATA = 32'hFFFF_FFFF;

  function automatic logic is_busy(input logic [1:0] st);
    return (st == BUSY_I) || (st == BUSY_D);
  endfunction

endpackage

// File: rtl/arb_sat_counter.sv
// Saturating up-counter with synchronous clear; sat flags count == LIMIT.
module arb_sat_counter #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned LIMIT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic sat
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  assign sat = (cnt_q == WIDTH'(LIMIT));

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !sat) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and load/store,
// data first with fetch starvation protection, and aborts unacknowledged accesses.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned AW           = 32,
  parameter int unsigned DW           = 32,
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned TIMEOUT      = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_ack,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic [DW-1:0] dm_rdata,
  output logic          dm_ack,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic          err
);

  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  logic [1:0]    state_q, state_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic [DW-1:0] dm_rdata_q, dm_rdata_d;
  logic          if_ack_q, if_ack_d;
  logic          dm_ack_q, dm_ack_d;
  logic          err_q, err_d;

  logic starve_inc, starve_clr, starve_sat;
  logic tmo_inc, tmo_clr, tmo_sat;
  logic busy;

  assign busy    = is_busy(state_q);
  assign tmo_inc = busy && !mem_ack;
  assign tmo_clr = !busy;

  arb_sat_counter #(.WIDTH(SW), .LIMIT(STARVE_LIMIT)) u_starve (
    .clk (clk),
    .rst (rst),
    .inc (starve_inc),
    .clr (starve_clr),
    .sat (starve_sat)
  );

  // Timeout counter sits at 0 in the first BUSY cycle, so sat marks the last one.
  arb_sat_counter #(.WIDTH(TW), .LIMIT(TIMEOUT - 1)) u_timeout (
    .clk (clk),
    .rst (rst),
    .inc (tmo_inc),
    .clr (tmo_clr),
    .sat (tmo_sat)
  );

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    if_ack_d    = 1'b0;
    dm_ack_d    = 1'b0;
    err_d       = 1'b0;
    starve_inc  = 1'b0;
    starve_clr  = 1'b0;

    case (state_q)
      IDLE: begin
        if (dm_req && (!if_req || !starve_sat)) begin
          state_d     = BUSY_D;
          mem_req_d   = 1'b1;
          mem_we_d    = dm_we;
          mem_addr_d  = dm_addr;
          mem_wdata_d = dm_wdata;
          starve_inc  = if_req;
          starve_clr  = !if_req;
        end else if (if_req) begin
          state_d     = BUSY_I;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = if_addr;
          mem_wdata_d = '0;
          starve_clr  = 1'b1;
        end
      end
      BUSY_I, BUSY_D: begin
        if (mem_ack || tmo_sat) begin
          state_d   = RESP;
          mem_req_d = 1'b0;
          err_d     = !mem_ack;
          if (state_q == BUSY_I) begin
            if_ack_d   = 1'b1;
            if_rdata_d = mem_ack ? mem_rdata : DW'(ERR_DATA);
          end else begin
            dm_ack_d   = 1'b1;
            dm_rdata_d = !mem_ack ? DW'(ERR_DATA) : (mem_we_q ? '0 : mem_rdata);
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      if_ack_q    <= 1'b0;
      dm_ack_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      if_ack_q    <= if_ack_d;
      dm_ack_q    <= dm_ack_d;
      err_q       <= err_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign if_ack    = if_ack_q;
  assign dm_ack    = dm_ack_q;
  assign err       = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vector table, hand-written
// corner sequences, and random traffic against a transaction-level model.
module tb_mem_port_arbiter;

  localparam int unsigned STARVE_LIMIT = 4;
  localparam int unsigned TIMEOUT      = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        dm_req = 1'b0;
  logic        dm_we = 1'b0;
  logic [31:0] dm_addr = '0;
  logic [31:0] dm_wdata = '0;
  logic [31:0] dm_rdata;
  logic        dm_ack;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic        err;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .AW(32), .DW(32), .STARVE_LIMIT(STARVE_LIMIT), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ack(dm_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .err(err)
  );

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string nm);
    chk(nm, {if_rdata, if_ack, dm_rdata, dm_ack, mem_req, mem_we, mem_addr, mem_wdata, err}, '0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    if_req = 1'b0; dm_req = 1'b0; mem_ack = 1'b0;
    tick();
    @(negedge clk);
    chk_all_zero("reset_outputs");
    rst = 1'b0;
    tick();
  endtask

  // Entered in an IDLE cycle with requests set up; returns in the following IDLE cycle.
  task automatic serve(input bit exp_d, input logic [31:0] exp_addr, input bit exp_we,
                       input logic [31:0] exp_wdata, input int lat, input logic [31:0] rd,
                       input logic [31:0] exp_rdata, input bit exp_err);
    tick();
    for (int k = 0; k < int'(TIMEOUT); k++) begin
      mem_ack   = (k == lat);
      mem_rdata = (k == lat) ? rd : $urandom;
      @(negedge clk);
      chk("busy_mem_req", mem_req, 1'b1);
      chk("busy_mem_bus", {mem_we, mem_addr, mem_wdata}, {exp_we, exp_addr, exp_wdata});
      chk("busy_no_ack", {if_ack, dm_ack, err}, 3'b000);
      tick();
      if (k == lat) break;
    end
    mem_ack = 1'($urandom_range(0, 1));
    if (exp_d) dm_req = 1'b0;
    else       if_req = 1'b0;
    @(negedge clk);
    chk("resp_acks", {if_ack, dm_ack}, exp_d ? 2'b01 : 2'b10);
    chk("resp_err", err, exp_err);
    chk("resp_rdata", exp_d ? dm_rdata : if_rdata, exp_rdata);
    chk("resp_mem_req", mem_req, 1'b0);
    tick();
    @(negedge clk);
    chk("ack_one_cycle", {if_ack, dm_ack, err, mem_req}, 4'b0000);
    mem_ack = 1'b0;
  endtask

  typedef struct {
    logic        ifr;
    logic [31:0] ia;
    logic        dr;
    logic        dw;
    logic [31:0] da;
    logic [31:0] dd;
    int          lat;
    logic [31:0] rd;
    logic        exp_d;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t tbl[8];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int starve;
    bit e_d, e_err, e_we;
    int lat;
    logic [31:0] rd;

    tbl[0] = '{1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0, 0, 32'h2002_0005, 1'b0, 32'h2002_0005, 1'b0};
    tbl[1] = '{1'b1, 32'h20, 1'b1, 1'b0, 32'h40, 32'h5555, 0, 32'hCAFE_0001, 1'b1, 32'hCAFE_0001, 1'b0};
    tbl[2] = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h80, 32'hDEAD_BEEF, 3, 32'h1234_5678, 1'b1, 32'h0, 1'b0};
    tbl[3] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'hC4, 32'h0, 15, 32'hA5A5_0F0F, 1'b1, 32'hA5A5_0F0F, 1'b0};
    tbl[4] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'hC8, 32'h0, 99, 32'h1, 1'b1, 32'hFFFF_FFFF, 1'b1};
    tbl[5] = '{1'b1, 32'h44, 1'b0, 1'b0, 32'h0, 32'h0, 40, 32'h2, 1'b0, 32'hFFFF_FFFF, 1'b1};
    tbl[6] = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h90, 32'h0BAD_F00D, 16, 32'h3, 1'b1, 32'hFFFF_FFFF, 1'b1};
    tbl[7] = '{1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0, 32'h0, 7, 32'h8765_4321, 1'b0, 32'h8765_4321, 1'b0};

    do_reset();

    // Directed single transactions from a freshly reset arbiter.
    for (int i = 0; i < 8; i++) begin
      do_reset();
      if_req = tbl[i].ifr; if_addr = tbl[i].ia;
      dm_req = tbl[i].dr;  dm_we = tbl[i].dw; dm_addr = tbl[i].da; dm_wdata = tbl[i].dd;
      serve(tbl[i].exp_d, tbl[i].exp_d ? tbl[i].da : tbl[i].ia, tbl[i].exp_d & tbl[i].dw,
            tbl[i].exp_d ? tbl[i].dd : 32'h0, tbl[i].lat, tbl[i].rd, tbl[i].exp_rdata,
            tbl[i].exp_err);
    end

    // Simultaneous requests: data wins, fetch is granted in the first IDLE after RESP.
    do_reset();
    if_req = 1'b1; if_addr = 32'h60;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h40; dm_wdata = 32'h0;
    serve(1'b1, 32'h40, 1'b0, 32'h0, 1, 32'h1111_2222, 32'h1111_2222, 1'b0);
    serve(1'b0, 32'h60, 1'b0, 32'h0, 0, 32'h3333_4444, 32'h3333_4444, 1'b0);

    // Starvation: four data grants, then fetch is forced and the counter clears.
    do_reset();
    if_req = 1'b1; if_addr = 32'h100;
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h200; dm_wdata = 32'h7;
    for (int i = 0; i < int'(STARVE_LIMIT); i++) begin
      serve(1'b1, 32'h200, 1'b1, 32'h7, 0, 32'h9, 32'h0, 1'b0);
      dm_req = 1'b1;
    end
    chk("starve_cnt_full", dut.u_starve.cnt_q, STARVE_LIMIT);
    serve(1'b0, 32'h100, 1'b0, 32'h0, 2, 32'h5A5A_5A5A, 32'h5A5A_5A5A, 1'b0);
    chk("starve_cnt_clear", dut.u_starve.cnt_q, 0);
    serve(1'b1, 32'h200, 1'b1, 32'h7, 0, 32'h9, 32'h0, 1'b0);

    // Reset in the middle of a data access; a late mem_ack must not produce an ack.
    do_reset();
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h300;
    tick();
    @(negedge clk);
    chk("pre_reset_busy", mem_req, 1'b1);
    rst = 1'b1; dm_req = 1'b0;
    tick();
    @(negedge clk);
    chk_all_zero("midreset_outputs");
    chk("midreset_state", dut.state_q, 2'd0);
    rst = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hBAD0_BAD0;
    tick();
    mem_ack = 1'b0;
    @(negedge clk);
    chk("late_ack_ignored", {if_ack, dm_ack, err, mem_req}, 4'b0000);
    tick();
    @(negedge clk);
    chk("late_ack_ignored2", {if_ack, dm_ack, err, mem_req, dm_rdata}, '0);

    // Random traffic against a transaction-level model of arbitration and completion.
    do_reset();
    starve = 0;
    for (int r = 0; r < 200; r++) begin
      if (!if_req) begin
        if_req  = ($urandom_range(0, 4) < 3);
        if_addr = $urandom;
      end
      if (!dm_req) begin
        dm_req   = ($urandom_range(0, 4) < 3);
        dm_we    = 1'($urandom_range(0, 1));
        dm_addr  = $urandom;
        dm_wdata = $urandom;
      end
      if (!if_req && !dm_req) begin
        tick();
        @(negedge clk);
        chk("rand_idle_no_req", mem_req, 1'b0);
      end else begin
        e_d   = dm_req && (!if_req || starve < int'(STARVE_LIMIT));
        lat   = int'($urandom_range(0, 19));
        rd    = $urandom;
        e_err = (lat >= int'(TIMEOUT));
        e_we  = e_d && dm_we;
        if (e_d && if_req) starve = (starve < int'(STARVE_LIMIT)) ? starve + 1 : starve;
        else               starve = 0;
        serve(e_d, e_d ? dm_addr : if_addr, e_we, e_d ? dm_wdata : 32'h0, lat, rd,
              e_err ? 32'hFFFF_FFFF : (e_we ? 32'h0 : rd), e_err);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
